fp16_result_packer: RTL and testbench



---
 rtl/fp16_result_packer.sv | 108 ++++++++++
 tb/tb_fp16_result_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_result_packer.sv
// Packs pairs of FP16 converter results into 32-bit words and streams them out
// through a first-word-fall-through FIFO with flush and sticky overflow.
module fp16_result_packer #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     res_valid,
   input  logic [15:0]              res_data,
   input  logic                     flush,
   input  logic                     clear_ovf,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [31:0]              m_data,
   output logic                     m_half,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_HALF  = 1'b1;

   logic          state;
   logic          state_nxt;
   logic [15:0]   lo_reg;
   logic          push;
   logic [32:0]   push_word;

   logic [32:0]   mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          accept;
   logic          drop;

   // A same-cycle sample and flush from EMPTY emits the sample as a half word directly
   always_comb begin
      push      = 1'b0;
      push_word = '0;
      state_nxt = state;
      if (res_valid) begin
         if (state == ST_HALF) begin
            push      = 1'b1;
            push_word = {1'b0, res_data, lo_reg};
            state_nxt = ST_EMPTY;
         end else if (flush) begin
            push      = 1'b1;
            push_word = {1'b1, 16'h0000, res_data};
         end else begin
            state_nxt = ST_HALF;
         end
      end else if (flush && (state == ST_HALF)) begin
         push      = 1'b1;
         push_word = {1'b1, 16'h0000, lo_reg};
         state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         lo_reg <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (res_valid && (state == ST_EMPTY) && !flush)
            lo_reg <= res_data;
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = m_valid && m_ready;
   assign accept     = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   // Head entry falls through; outputs are forced to zero while the FIFO is empty
   assign level   = wr_ptr - rd_ptr;
   assign m_valid = !fifo_empty;
   assign m_data  = fifo_empty ? 32'h0000_0000 : mem[rd_ptr[AW-1:0]][31:0];
   assign m_half  = fifo_empty ? 1'b0 : mem[rd_ptr[AW-1:0]][32];

endmodule

// File: tb/tb_fp16_result_packer.sv
// Scoreboard bench for fp16_result_packer: stimulus queues expected words,
// a negedge monitor pops and compares them whenever the DUT hands one over.
module tb_fp16_result_packer;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          res_valid;
   logic [15:0]   res_data;
   logic          flush;
   logic          clear_ovf;
   logic          m_valid;
   logic          m_ready;
   logic [31:0]   m_data;
   logic          m_half;
   logic [LW-1:0] level;
   logic          overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [32:0] exp_q[$];
   logic        mdl_half_state;
   logic [15:0] mdl_lo;
   int          mdl_level;
   logic        mdl_ovf;

   fp16_result_packer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .res_valid (res_valid),
      .res_data  (res_data),
      .flush     (flush),
      .clear_ovf (clear_ovf),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_half    (m_half),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [32:0] actual, input logic [32:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, updates the reference model, then checks level/overflow after the edge
   task automatic apply_stimulus(input logic rv, input logic [15:0] d, input logic fl,
                                 input logic clr, input logic rdy);
      logic        do_push;
      logic [32:0] word;
      logic        do_pop;
      logic        dropped;
      int          next_level;
      res_valid = rv;
      res_data  = d;
      flush     = fl;
      clear_ovf = clr;
      m_ready   = rdy;
      do_push   = 1'b0;
      word      = '0;
      dropped   = 1'b0;
      if (rv) begin
         if (mdl_half_state) begin
            do_push        = 1'b1;
            word           = {1'b0, d, mdl_lo};
            mdl_half_state = 1'b0;
         end else if (fl) begin
            do_push = 1'b1;
            word    = {1'b1, 16'h0000, d};
         end else begin
            mdl_lo         = d;
            mdl_half_state = 1'b1;
         end
      end else if (fl && mdl_half_state) begin
         do_push        = 1'b1;
         word           = {1'b1, 16'h0000, mdl_lo};
         mdl_half_state = 1'b0;
      end
      do_pop     = rdy && (mdl_level != 0);
      next_level = mdl_level;
      if (do_push) begin
         if ((mdl_level < DEPTH) || do_pop) begin
            exp_q.push_back(word);
            next_level++;
         end else begin
            dropped = 1'b1;
         end
      end
      if (do_pop)
         next_level--;
      @(posedge clk);
      #1;
      mdl_level = next_level;
      if (dropped)
         mdl_ovf = 1'b1;
      else if (clr)
         mdl_ovf = 1'b0;
      check_output("level", 33'(level), 33'(mdl_level));
      check_output("overflow", 33'(overflow), 33'(mdl_ovf));
   endtask

   task automatic model_reset();
      exp_q.delete();
      mdl_half_state = 1'b0;
      mdl_lo         = 16'h0000;
      mdl_level      = 0;
      mdl_ovf        = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_m_valid"}, 33'(m_valid), 33'd0);
      check_output({tag, "_m_data"}, 33'(m_data), 33'd0);
      check_output({tag, "_m_half"}, 33'(m_half), 33'd0);
      check_output({tag, "_level"}, 33'(level), 33'd0);
      check_output({tag, "_overflow"}, 33'(overflow), 33'd0);
   endtask

   // Monitor: compares the head word on every accepted transfer, and idle outputs when empty
   initial begin
      forever begin
         @(negedge clk);
         check_output("m_valid_vs_level", 33'(m_valid), 33'(mdl_level != 0));
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_word", {m_half, m_data}, 33'h1_FFFF_FFFF);
            end else begin
               check_output("word", {m_half, m_data}, exp_q.pop_front());
            end
         end else if (!m_valid) begin
            check_output("idle_outputs", {m_half, m_data}, 33'd0);
         end
      end
   end

   initial begin
      model_reset();
      rst_n     = 1'b0;
      res_valid = 1'b0;
      res_data  = 16'h0000;
      flush     = 1'b0;
      clear_ovf = 1'b0;
      m_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Simple pair
      apply_stimulus(1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'h4000, 1'b0, 1'b0, 1'b1);
      repeat (2) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Odd burst with flush, then a flush with nothing pending
      apply_stimulus(1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'h4000, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'h4200, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      repeat (2) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Overflow: 2*DEPTH+2 results into a stalled FIFO
      for (int i = 0; i < 2 * DEPTH + 2; i++)
         apply_stimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
      check_output("ovf_set", 33'(overflow), 33'd1);
      check_output("ovf_level", 33'(level), 33'(DEPTH));
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      check_output("ovf_cleared", 33'(overflow), 33'd0);

      // Full FIFO: pair completes in the same cycle as a pop
      apply_stimulus(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1);
      check_output("full_pushpop_level", 33'(level), 33'(DEPTH));
      check_output("full_pushpop_ovf", 33'(overflow), 33'd0);
      repeat (DEPTH + 2) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Sample plus flush from EMPTY, then from HALF
      apply_stimulus(1'b1, 16'hC500, 1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'h3C00, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'hC500, 1'b1, 1'b0, 1'b1);
      repeat (2) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Reset while HALF with three words queued
      for (int i = 0; i < 7; i++)
         apply_stimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
      check_output("pre_reset_level", 33'(level), 33'd3);
      res_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply_stimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1);
      repeat (2) apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      check_output("scoreboard_drained", 33'(exp_q.size()), 33'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
